// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dmem_state_e;

    localparam logic [31:0] DMEM_POISON          = 32'hDEAD_BEEF;
    localparam int unsigned DMEM_TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/dmem_timeout.sv
// ACCESS-cycle counter with an expire flag; only instantiated when DMEM_TIMEOUT_EN is defined.
module dmem_timeout
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DMEM_TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expires combinationally in the TIMEOUT_CYC-th ACCESS cycle so DONE follows immediately.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller that stalls the pipeline for multi-cycle loads/stores.
// Optional abort on missing ack: define DMEM_TIMEOUT_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DMEM_TIMEOUT_CYC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] Memdata_o,
    output logic        stall_o,
    output logic        err_o
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("dmem_ctrl: TIMEOUT_CYC must be nonzero");
    end

    dmem_state_e state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_op;
    logic        access_start;
    logic        timeout_hit;

    assign mem_op = MemRead_i || MemWrite_i;

`ifdef DMEM_TIMEOUT_EN
    logic err_q, err_d;

    dmem_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (access_start),
        .en_i     (state_q == ST_ACCESS),
        .expired_o(timeout_hit)
    );

    assign err_o = err_q;

    always_comb begin
        err_d = err_q;
        if ((state_q == ST_ACCESS) && !mem_ack_i && timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        access_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d      = ST_ACCESS;
                    we_d         = MemWrite_i;
                    addr_d       = addr_i;
                    wdata_d      = wdata_i;
                    access_start = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    if (!we_q) begin
                        rdata_d = DMEM_POISON;
                    end
                    state_d = ST_DONE;
                end
            end
            // The same instruction is still in EX/MEM here, so its controls are ignored.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req_o   = (state_q == ST_ACCESS);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign Memdata_o   = rdata_q;
    assign stall_o     = ((state_q == ST_IDLE) && mem_op) || (state_q == ST_ACCESS);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus queues expected requests/results, a monitor checks them.
module tb_dmem_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] Memdata_o;
    logic        stall_o;
    logic        err_o;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] md;
        logic        err;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    req_t cur;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_starts = 0;
    int exp_reqs = 0;
    logic prev_req = 1'b0;

    dmem_ctrl #(
        .TIMEOUT_CYC(4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .Memdata_o  (Memdata_o),
        .stall_o    (stall_o),
        .err_o      (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=event required=none", name);
    endtask

    // Monitor: request start, hold stability while requesting, result in the DONE cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                prev_req = 1'b0;
            end else begin
                if (mem_req_o && !prev_req) begin
                    n_starts++;
                    if (req_q.size() == 0) begin
                        note_fail("unexpected_request");
                    end else begin
                        cur = req_q.pop_front();
                        chk("req_addr", mem_addr_o, cur.addr);
                        chk("req_we", {31'd0, mem_we_o}, {31'd0, cur.we});
                        chk("req_wdata", mem_wdata_o, cur.wdata);
                    end
                end else if (mem_req_o && prev_req) begin
                    chk("hold_addr", mem_addr_o, cur.addr);
                    chk("hold_we", {31'd0, mem_we_o}, {31'd0, cur.we});
                    chk("hold_wdata", mem_wdata_o, cur.wdata);
                end else if (!mem_req_o && prev_req) begin
                    if (res_q.size() == 0) begin
                        note_fail("unexpected_done");
                    end else begin
                        res_t r;
                        r = res_q.pop_front();
                        chk("done_memdata", Memdata_o, r.md);
                        chk("done_err", {31'd0, err_o}, {31'd0, r.err});
                        chk("done_stall", {31'd0, stall_o}, 32'd0);
                    end
                end
                prev_req = mem_req_o;
            end
        end
    end

    // Full access; ack_dly = number of ACCESS cycles before the ack cycle (-1: never ack).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_dly,
                             input logic [31:0] rdata, input logic [31:0] exp_md,
                             input logic exp_err, input int exp_stalls);
        int  stalls;
        bit  done;
        req_t q;
        res_t r;
        stalls = 0;
        done   = 1'b0;
        @(posedge clk_i); #1;
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = addr;
        wdata_i    = wdata;
        q.we = wr; q.addr = addr; q.wdata = wdata;
        r.md = exp_md; r.err = exp_err;
        req_q.push_back(q);
        res_q.push_back(r);
        exp_reqs++;
        #1;
        if (stall_o) stalls++;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk_i); #1;
            mem_ack_i   = (c == ack_dly);
            mem_rdata_i = (c == ack_dly) ? rdata : 32'hFFFF_0000;
            #1;
            if (stall_o) stalls++;
            else done = 1'b1;
        end
        if (!done) note_fail("access_never_completed");
        chk("stall_cycles", stalls, exp_stalls);
        // Controls still held through DONE; released in the following cycle.
        @(posedge clk_i); #1;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        mem_ack_i  = 1'b0;
        #1;
        chk("post_done_req", {31'd0, mem_req_o}, 32'd0);
        chk("post_done_stall", {31'd0, stall_o}, 32'd0);
    endtask

    initial begin
        rst_i       = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_memdata", Memdata_o, 32'h0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        rst_i = 1'b1;

        // Idle cycles with no request.
        repeat (2) @(posedge clk_i);
        #1;
        chk("idle_req", {31'd0, mem_req_o}, 32'd0);
        chk("idle_stall", {31'd0, stall_o}, 32'd0);

        // Load 0x10, ack in first ACCESS cycle.
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2);

        // Store 0x20, five ACCESS cycles; load result untouched.
        do_access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 4, 32'h5555_AAAA, 32'h1234_5678, 1'b0, 6);

        // Stray ack while idle, then read+write together behaves as a write.
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        @(posedge clk_i); #1;
        chk("stray_ack_req", {31'd0, mem_req_o}, 32'd0);
        chk("stray_ack_memdata", Memdata_o, 32'h1234_5678);
        do_access(1'b1, 1'b1, 32'h30, 32'h0BAD_CAFE, 1, 32'h7777_7777, 32'h1234_5678, 1'b0, 3);

        // Load 0x44 with two wait cycles.
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 2, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 4);

        // Reset during the third ACCESS cycle of a load.
        @(posedge clk_i); #1;
        MemRead_i = 1'b1;
        addr_i    = 32'h50;
        cur.we = 1'b0; cur.addr = 32'h50; cur.wdata = 32'h0;
        req_q.push_back(cur);
        exp_reqs++;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        MemRead_i = 1'b0;
        #1;
        chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
        chk("midrst_we", {31'd0, mem_we_o}, 32'd0);
        chk("midrst_addr", mem_addr_o, 32'h0);
        chk("midrst_wdata", mem_wdata_o, 32'h0);
        chk("midrst_memdata", Memdata_o, 32'h0);
        chk("midrst_err", {31'd0, err_o}, 32'd0);
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h9999_9999;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        #1;
        chk("late_ack_req", {31'd0, mem_req_o}, 32'd0);
        chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
        chk("late_ack_memdata", Memdata_o, 32'h0);

`ifdef DMEM_TIMEOUT_EN
        // No ack: abort after four ACCESS cycles with poison data and sticky error.
        do_access(1'b1, 1'b0, 32'h60, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 1'b1, 5);
        repeat (2) @(posedge clk_i);
        #1;
        chk("err_sticky", {31'd0, err_o}, 32'd1);
`endif

        repeat (3) @(posedge clk_i);
        #1;
        chk("request_count", n_starts, exp_reqs);
        chk("req_queue_empty", req_q.size(), 32'd0);
        chk("res_queue_empty", res_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
